rs_fp: RTL and testbench

RS_FP -- requirements
Module: rs_fp

---
 rtl/fp_rs_pkg.sv | 42 ++++
 rtl/rs_fp_slot.sv | 45 ++++
 rtl/rs_fp.sv | 91 +++++++++
 tb/tb_rs_fp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fp_rs_pkg.sv
// fp_rs_pkg: shared FP reservation-station layout, sizes and the wakeup helper
package fp_rs_pkg;

    localparam int ENTRY_W = 114;
    localparam int TAG_W   = 4;
    localparam int SLOTS   = 2;
    localparam int RS1_RDY = 5;
    localparam int RS1_VAL = 6;
    localparam int RS2_RDY = 38;
    localparam int RS2_VAL = 39;
    localparam int ROB_LSB = 72;
    localparam int RS1_TAG = 81;
    localparam int RS2_TAG = 85;

    // Capture CDB data into every still-waiting operand whose tag matches; port 0 wins ties.
    function automatic logic [ENTRY_W-1:0] wake(
        input logic [ENTRY_W-1:0] e,
        input logic               v0,
        input logic [TAG_W-1:0]   t0,
        input logic [31:0]        d0,
        input logic               v1,
        input logic [TAG_W-1:0]   t1,
        input logic [31:0]        d1
    );
        logic [ENTRY_W-1:0] r;
        r = e;
        if (!e[RS1_RDY]) begin
            if (v0 && t0 == e[RS1_TAG +: TAG_W])
                {r[RS1_VAL +: 32], r[RS1_RDY]} = {d0, 1'b1};
            else if (v1 && t1 == e[RS1_TAG +: TAG_W])
                {r[RS1_VAL +: 32], r[RS1_RDY]} = {d1, 1'b1};
        end
        if (!e[RS2_RDY]) begin
            if (v0 && t0 == e[RS2_TAG +: TAG_W])
                {r[RS2_VAL +: 32], r[RS2_RDY]} = {d0, 1'b1};
            else if (v1 && t1 == e[RS2_TAG +: TAG_W])
                {r[RS2_VAL +: 32], r[RS2_RDY]} = {d1, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_fp_slot.sv
// rs_fp_slot: one FP reservation-station slot with operand wakeup on the CDB
module rs_fp_slot
    import fp_rs_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_load,
    input  logic [ENTRY_W-1:0] i_entry,
    input  logic               i_issue,
    input  logic               i_cdb0_valid,
    input  logic [TAG_W-1:0]   i_cdb0_rob_num,
    input  logic [31:0]        i_cdb0_data,
    input  logic               i_cdb1_valid,
    input  logic [TAG_W-1:0]   i_cdb1_rob_num,
    input  logic [31:0]        i_cdb1_data,
    output logic               o_valid,
    output logic [ENTRY_W-1:0] o_entry
);

    logic               r_valid;
    logic [ENTRY_W-1:0] r_entry;

    // Load only happens into an empty slot, so issue never competes with it; an empty slot stays zeroed.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_entry <= wake(i_entry, i_cdb0_valid, i_cdb0_rob_num, i_cdb0_data,
                            i_cdb1_valid, i_cdb1_rob_num, i_cdb1_data);
        end else if (i_issue) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (r_valid) begin
            r_entry <= wake(r_entry, i_cdb0_valid, i_cdb0_rob_num, i_cdb0_data,
                            i_cdb1_valid, i_cdb1_rob_num, i_cdb1_data);
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;

endmodule

// File: rtl/rs_fp.sv
// rs_fp: two-slot FP reservation station; define FP_RS_CDB1_EN to add the second CDB wakeup port
module rs_fp
    import fp_rs_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               disp_valid,
    input  logic [ENTRY_W-1:0] disp_entry,
    output logic               disp_ready,
    input  logic               cdb0_valid,
    input  logic [TAG_W-1:0]   cdb0_rob_num,
    input  logic [31:0]        cdb0_data,
`ifdef FP_RS_CDB1_EN
    input  logic               cdb1_valid,
    input  logic [TAG_W-1:0]   cdb1_rob_num,
    input  logic [31:0]        cdb1_data,
`endif
    output logic [ENTRY_W-1:0] rs_fp_0,
    output logic [ENTRY_W-1:0] rs_fp_1,
    output logic [TAG_W-1:0]   rs_fp_0_entry_num,
    output logic [TAG_W-1:0]   rs_fp_1_entry_num,
    output logic               selector,
    input  logic               fp_0_issue,
    input  logic               fp_1_issue
);

    logic               w_cdb1_valid;
    logic [TAG_W-1:0]   w_cdb1_rob_num;
    logic [31:0]        w_cdb1_data;
    logic [SLOTS-1:0]   w_valid;
    logic [SLOTS-1:0]   w_issue;
    logic [SLOTS-1:0]   w_load;
    logic [SLOTS-1:0]   w_next;
    logic [ENTRY_W-1:0] w_entry [SLOTS];
    logic               w_acc;
    logic               r_sel;

`ifdef FP_RS_CDB1_EN
    assign w_cdb1_valid   = cdb1_valid;
    assign w_cdb1_rob_num = cdb1_rob_num;
    assign w_cdb1_data    = cdb1_data;
`else
    assign w_cdb1_valid   = 1'b0;
    assign w_cdb1_rob_num = '0;
    assign w_cdb1_data    = '0;
`endif

    assign disp_ready = !(&w_valid);
    assign w_acc      = disp_valid && disp_ready;
    assign w_issue    = {fp_1_issue, fp_0_issue};
    assign w_load     = {w_acc && w_valid[0] && !w_valid[1], w_acc && !w_valid[0]};
    assign w_next     = w_load | (w_valid & ~w_issue);

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        rs_fp_slot u_slot (
            .clk            (clk),
            .rst            (rst),
            .i_flush        (flush),
            .i_load         (w_load[g]),
            .i_entry        (disp_entry),
            .i_issue        (w_issue[g]),
            .i_cdb0_valid   (cdb0_valid),
            .i_cdb0_rob_num (cdb0_rob_num),
            .i_cdb0_data    (cdb0_data),
            .i_cdb1_valid   (w_cdb1_valid),
            .i_cdb1_rob_num (w_cdb1_rob_num),
            .i_cdb1_data    (w_cdb1_data),
            .o_valid        (w_valid[g]),
            .o_entry        (w_entry[g])
        );
    end

    // Selector follows a fresh dispatch, else the lone valid slot, else holds when both stay valid.
    always_ff @(posedge clk) begin
        if (rst || flush)
            r_sel <= 1'b0;
        else
            r_sel <= w_load[0] ? 1'b0 :
                     w_load[1] ? 1'b1 :
                     (w_next[0] ^ w_next[1]) ? w_next[1] :
                     (&w_next) ? r_sel : 1'b0;
    end

    assign rs_fp_0           = w_entry[0];
    assign rs_fp_1           = w_entry[1];
    assign rs_fp_0_entry_num = w_entry[0][ROB_LSB +: TAG_W];
    assign rs_fp_1_entry_num = w_entry[1][ROB_LSB +: TAG_W];
    assign selector          = r_sel;

endmodule

// File: tb/tb_rs_fp.sv
// tb_rs_fp: randomized and directed checks of rs_fp against a field-level slot model
module tb_rs_fp;

    typedef struct {
        logic [4:0]  rd;
        logic        r1rdy;
        logic [31:0] r1val;
        logic        r2rdy;
        logic [31:0] r2val;
        logic        fw;
        logic [3:0]  rob;
        logic [4:0]  op;
        logic [3:0]  t1;
        logic [3:0]  t2;
    } ent_t;

    logic         clk = 0;
    logic         rst, flush, disp_valid, disp_ready;
    logic [113:0] disp_entry, rs_fp_0, rs_fp_1;
    logic         cdb0_valid, cdb1_valid;
    logic [3:0]   cdb0_rob_num, cdb1_rob_num, rs_fp_0_entry_num, rs_fp_1_entry_num;
    logic [31:0]  cdb0_data, cdb1_data;
    logic         selector, fp_0_issue, fp_1_issue;

    ent_t d_ent;
    ent_t me [2];
    logic mv [2];
    logic msel;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    rs_fp dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .disp_valid        (disp_valid),
        .disp_entry        (disp_entry),
        .disp_ready        (disp_ready),
        .cdb0_valid        (cdb0_valid),
        .cdb0_rob_num      (cdb0_rob_num),
        .cdb0_data         (cdb0_data),
`ifdef FP_RS_CDB1_EN
        .cdb1_valid        (cdb1_valid),
        .cdb1_rob_num      (cdb1_rob_num),
        .cdb1_data         (cdb1_data),
`endif
        .rs_fp_0           (rs_fp_0),
        .rs_fp_1           (rs_fp_1),
        .rs_fp_0_entry_num (rs_fp_0_entry_num),
        .rs_fp_1_entry_num (rs_fp_1_entry_num),
        .selector          (selector),
        .fp_0_issue        (fp_0_issue),
        .fp_1_issue        (fp_1_issue)
    );

    task automatic chk(input string tag, input logic [113:0] got, input logic [113:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [113:0] pack(input ent_t e);
        return {25'b0, e.t2, e.t1, e.op, e.rob, e.fw, e.r2val, e.r2rdy, e.r1val, e.r1rdy, e.rd};
    endfunction

    function automatic logic cdb_hit(input logic [3:0] t, output logic [31:0] d);
        logic c1v;
`ifdef FP_RS_CDB1_EN
        c1v = cdb1_valid;
`else
        c1v = 1'b0;
`endif
        d = 0;
        if (cdb0_valid && cdb0_rob_num == t) begin d = cdb0_data; return 1; end
        if (c1v && cdb1_rob_num == t) begin d = cdb1_data; return 1; end
        return 0;
    endfunction

    function automatic ent_t wk(input ent_t e);
        ent_t r = e;
        logic [31:0] d;
        if (!e.r1rdy && cdb_hit(e.t1, d)) begin r.r1rdy = 1; r.r1val = d; end
        if (!e.r2rdy && cdb_hit(e.t2, d)) begin r.r2rdy = 1; r.r2val = d; end
        return r;
    endfunction

    task automatic idle();
        rst = 0; flush = 0; disp_valid = 0; fp_0_issue = 0; fp_1_issue = 0;
        cdb0_valid = 0; cdb1_valid = 0;
    endtask

    task automatic mk(input logic [3:0] rob, input logic r1, input logic [3:0] t1,
                      input logic r2, input logic [3:0] t2);
        d_ent.rd = 5'($urandom); d_ent.fw = 1'($urandom); d_ent.op = 5'($urandom);
        d_ent.r1val = r1 ? $urandom : 0; d_ent.r2val = r2 ? $urandom : 0;
        d_ent.rob = rob; d_ent.r1rdy = r1; d_ent.t1 = t1; d_ent.r2rdy = r2; d_ent.t2 = t2;
        disp_entry = pack(d_ent);
    endtask

    task automatic step();
        ent_t ne [2];
        logic nv [2];
        logic ns, acc, iss;
        int   k;
        ne = me; nv = mv; ns = msel;
        if (rst || flush) begin
            nv[0] = 0; nv[1] = 0; ns = 0;
        end else begin
            acc = disp_valid && !(mv[0] && mv[1]);
            k = mv[0] ? 1 : 0;
            for (int n = 0; n < 2; n++) begin
                iss = n == 0 ? fp_0_issue : fp_1_issue;
                if (mv[n] && iss) nv[n] = 0;
                else if (mv[n]) ne[n] = wk(me[n]);
            end
            if (acc) begin nv[k] = 1; ne[k] = wk(d_ent); end
            if (acc) ns = k[0];
            else if (nv[0] != nv[1]) ns = nv[1];
            else if (!nv[0]) ns = 0;
        end
        @(posedge clk);
        #1;
        me = ne; mv = nv; msel = ns;
        chk("rs_fp_0", rs_fp_0, mv[0] ? pack(me[0]) : 114'd0);
        chk("rs_fp_1", rs_fp_1, mv[1] ? pack(me[1]) : 114'd0);
        chk("entry_num_0", 114'(rs_fp_0_entry_num), mv[0] ? 114'(me[0].rob) : 114'd0);
        chk("entry_num_1", 114'(rs_fp_1_entry_num), mv[1] ? 114'(me[1].rob) : 114'd0);
        chk("selector", 114'(selector), 114'(msel));
        chk("disp_ready", 114'(disp_ready), 114'(!(mv[0] && mv[1])));
    endtask

    initial begin
        mv[0] = 0; mv[1] = 0; msel = 0;
        idle();
        mk(0, 1, 0, 1, 0);
        cdb0_rob_num = 0; cdb0_data = 0; cdb1_rob_num = 0; cdb1_data = 0;
        rst = 1; step(); step();
        idle();
        chk("rst_ready", 114'(disp_ready), 114'd1);
        chk("rst_sel", 114'(selector), 114'd0);
        chk("rst_slot0", rs_fp_0, 114'd0);

        mk(3, 1, 1, 1, 1); disp_valid = 1; step();
        chk("d31_rob", 114'(rs_fp_0_entry_num), 114'd3);
        chk("d31_ready", 114'(disp_ready), 114'd1);
        mk(5, 1, 1, 1, 1); step();
        mk(9, 1, 1, 1, 1); step();
        chk("d32_ready", 114'(disp_ready), 114'd0);
        chk("d32_rob1", 114'(rs_fp_1_entry_num), 114'd5);
        chk("d32_sel", 114'(selector), 114'd1);

        idle(); flush = 1; step(); idle();
        mk(3, 1, 1, 0, 7); disp_valid = 1; step(); idle();
        cdb0_valid = 1; cdb0_rob_num = 7; cdb0_data = 32'h3F800000; step(); idle();
        chk("d33_rdy", 114'(rs_fp_0[38]), 114'd1);
        chk("d33_val", 114'(rs_fp_0[70:39]), 114'h3F800000);

        mk(5, 1, 1, 1, 1); disp_valid = 1; step();
        mk(6, 1, 1, 1, 1); fp_0_issue = 1; step();
        chk("d34_free", rs_fp_0, 114'd0);
        fp_0_issue = 0; step(); idle();
        chk("d34_rob", 114'(rs_fp_0_entry_num), 114'd6);
        chk("d34_sel", 114'(selector), 114'd0);

        flush = 1; step(); idle();
        mk(4, 0, 2, 1, 1); disp_valid = 1;
        cdb0_valid = 1; cdb0_rob_num = 2; cdb0_data = 32'h40000000; step(); idle();
        chk("d35_rdy", 114'(rs_fp_0[5]), 114'd1);
        chk("d35_val", 114'(rs_fp_0[37:6]), 114'h40000000);

        mk(8, 1, 1, 1, 1); disp_valid = 1; step();
        flush = 1; mk(9, 1, 1, 1, 1); step(); idle();
        chk("d36_s0", rs_fp_0, 114'd0);
        chk("d36_s1", rs_fp_1, 114'd0);
        chk("d36_ready", 114'(disp_ready), 114'd1);

        for (int i = 0; i < 500; i++) begin
            mk(4'($urandom), 1'($urandom), 4'($urandom_range(0, 7)),
               1'($urandom), 4'($urandom_range(0, 7)));
            rst          = $urandom_range(0, 99) == 0;
            flush        = $urandom_range(0, 29) == 0;
            disp_valid   = $urandom_range(0, 1) == 1;
            fp_0_issue   = $urandom_range(0, 3) == 0;
            fp_1_issue   = $urandom_range(0, 3) == 0;
            cdb0_valid   = $urandom_range(0, 1) == 1;
            cdb0_rob_num = 4'($urandom_range(0, 7));
            cdb0_data    = $urandom;
            cdb1_valid   = $urandom_range(0, 1) == 1;
            cdb1_rob_num = 4'($urandom_range(0, 7));
            cdb1_data    = $urandom;
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
